// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game control blocks.
package flappy_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, FLASH, OVER} game_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_over_ctrl_if.sv
// Game-event inputs and display/status outputs of the game-over controller.
interface game_over_ctrl_if #(parameter int ROWS = 16);
    import flappy_pkg::*;

    localparam int RW = $clog2(ROWS);

    logic            start;
    logic            tick;
    logic [RW-1:0]   bird_row;
    logic [ROWS-1:0] pipe_col;
    logic            pipe_pass;
    logic            press;
    logic            playing;
    logic            freeze;
    logic            flash;
    logic            over;
    logic            clear_req;
    bcd_t            score_tens;
    bcd_t            score_ones;

    modport master (
        output start, tick, bird_row, pipe_col, pipe_pass, press,
        input  playing, freeze, flash, over, clear_req, score_tens, score_ones
    );

    modport slave (
        input  start, tick, bird_row, pipe_col, pipe_pass, press,
        output playing, freeze, flash, over, clear_req, score_tens, score_ones
    );

endinterface

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter: synchronous clear, increment saturating at 99.
module bcd_score_counter
    import flappy_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output bcd_t tens,
    output bcd_t ones
);

    bcd_t tens_reg;
    bcd_t ones_reg;
    logic at_max;

    assign at_max = (tens_reg == BCD_MAX) && (ones_reg == BCD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_reg <= '0;
            ones_reg <= '0;
        end else if (clr) begin
            tens_reg <= '0;
            ones_reg <= '0;
        end else if (inc && !at_max) begin
            if (ones_reg == BCD_MAX) begin
                ones_reg <= '0;
                tens_reg <= tens_reg + 4'd1;
            end else begin
                ones_reg <= ones_reg + 4'd1;
            end
        end
    end

    assign tens = tens_reg;
    assign ones = ones_reg;

endmodule

// File: rtl/game_over_ctrl.sv
// Detects bird collisions, blinks and freezes the board, then holds a game-over
// state until a press (after a holdoff) issues a one-cycle clear request.
module game_over_ctrl
    import flappy_pkg::*;
#(
    parameter int ROWS          = 16,
    parameter int FLASH_TICKS   = 6,
    parameter int HOLDOFF_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    game_over_ctrl_if.slave  bus
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(max_int(FLASH_TICKS, HOLDOFF_TICKS) + 1);
    localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLDOFF_TICKS);

    game_state_t     state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            playing_reg;
    logic            freeze_reg;
    logic            flash_reg;
    logic            over_reg;
    logic            clear_req_reg;

    logic [ROWS-1:0] row_hit;
    logic            hit;
    logic            cnt_zero;
    logic            accept;
    logic            score_inc;
    logic            score_clr;

    // One-hot match of the bird row against the pipe occupancy column.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_hit
            assign row_hit[gi] = bus.pipe_col[gi] && (bus.bird_row == RW'(gi));
        end
    endgenerate

    assign hit      = bus.tick && ((|row_hit) || (bus.bird_row == '0));
    assign cnt_zero = (cnt_reg == '0);
    assign accept   = (state_reg == OVER) && bus.press && cnt_zero;

    // A running game whose start level drops is abandoned before any hit check.
    assign score_clr = (state_reg == IDLE) || ((state_reg == PLAY) && !bus.start) || accept;
    assign score_inc = (state_reg == PLAY) && bus.start && !hit && bus.tick && bus.pipe_pass;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            playing_reg   <= 1'b0;
            freeze_reg    <= 1'b0;
            flash_reg     <= 1'b0;
            over_reg      <= 1'b0;
            clear_req_reg <= 1'b0;
        end else begin
            clear_req_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg   <= PLAY;
                        playing_reg <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!bus.start) begin
                        state_reg   <= IDLE;
                        playing_reg <= 1'b0;
                    end else if (hit) begin
                        state_reg   <= FLASH;
                        playing_reg <= 1'b0;
                        freeze_reg  <= 1'b1;
                        flash_reg   <= 1'b1;
                        cnt_reg     <= FLASH_LOAD;
                    end
                end
                FLASH: begin
                    if (bus.tick) begin
                        if (cnt_zero) begin
                            state_reg <= OVER;
                            flash_reg <= 1'b0;
                            over_reg  <= 1'b1;
                            cnt_reg   <= HOLD_LOAD;
                        end else begin
                            cnt_reg   <= cnt_reg - 1'b1;
                            flash_reg <= ~flash_reg;
                        end
                    end
                end
                OVER: begin
                    if (accept) begin
                        state_reg     <= IDLE;
                        over_reg      <= 1'b0;
                        freeze_reg    <= 1'b0;
                        clear_req_reg <= 1'b1;
                    end else if (bus.tick && !cnt_zero) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    bcd_score_counter u_score (
        .clk   (clk),
        .reset (reset),
        .inc   (score_inc),
        .clr   (score_clr),
        .tens  (bus.score_tens),
        .ones  (bus.score_ones)
    );

    assign bus.playing   = playing_reg;
    assign bus.freeze    = freeze_reg;
    assign bus.flash     = flash_reg;
    assign bus.over      = over_reg;
    assign bus.clear_req = clear_req_reg;

endmodule

// File: tb/tb_game_over_ctrl.sv
// Directed plus randomized check of game_over_ctrl against an integer-score,
// tick-counting reference model.
module tb_game_over_ctrl;

    localparam int ROWS          = 16;
    localparam int FLASH_TICKS   = 6;
    localparam int HOLDOFF_TICKS = 4;

    localparam int PH_IDLE  = 0;
    localparam int PH_PLAY  = 1;
    localparam int PH_FLASH = 2;
    localparam int PH_OVER  = 3;

    logic clk;
    logic reset;

    game_over_ctrl_if #(.ROWS(ROWS)) bus ();

    game_over_ctrl #(
        .ROWS          (ROWS),
        .FLASH_TICKS   (FLASH_TICKS),
        .HOLDOFF_TICKS (HOLDOFF_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: phase, integer score, ticks seen since phase entry.
    int m_phase;
    int m_score;
    int m_fticks;
    int m_oticks;
    bit m_clr;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_phase  = PH_IDLE;
        m_score  = 0;
        m_fticks = 0;
        m_oticks = 0;
        m_clr    = 1'b0;
    endtask

    task automatic m_update();
        logic [15:0] pc;
        pc    = bus.pipe_col;
        m_clr = 1'b0;
        case (m_phase)
            PH_IDLE: if (bus.start) m_phase = PH_PLAY;
            PH_PLAY: begin
                if (!bus.start) begin
                    m_phase = PH_IDLE;
                    m_score = 0;
                end else if (bus.tick && (pc[bus.bird_row] || bus.bird_row == 0)) begin
                    m_phase  = PH_FLASH;
                    m_fticks = 0;
                end else if (bus.tick && bus.pipe_pass && m_score < 99) begin
                    m_score++;
                end
            end
            PH_FLASH: if (bus.tick) begin
                m_fticks++;
                if (m_fticks == FLASH_TICKS) begin
                    m_phase  = PH_OVER;
                    m_oticks = 0;
                end
            end
            default: begin
                if (bus.press && m_oticks >= HOLDOFF_TICKS) begin
                    m_phase = PH_IDLE;
                    m_score = 0;
                    m_clr   = 1'b1;
                end else if (bus.tick) begin
                    m_oticks++;
                end
            end
        endcase
    endtask

    task automatic check_model();
        chk("playing",    bus.playing,    8'(m_phase == PH_PLAY));
        chk("freeze",     bus.freeze,     8'(m_phase == PH_FLASH || m_phase == PH_OVER));
        chk("flash",      bus.flash,      8'(m_phase == PH_FLASH && (m_fticks % 2) == 0));
        chk("over",       bus.over,       8'(m_phase == PH_OVER));
        chk("clear_req",  bus.clear_req,  8'(m_clr));
        chk("score_tens", bus.score_tens, 8'(m_score / 10));
        chk("score_ones", bus.score_ones, 8'(m_score % 10));
    endtask

    task automatic step(input logic st, input logic tk, input logic [3:0] br,
                        input logic [15:0] pc, input logic pp, input logic pr);
        bus.start     = st;
        bus.tick      = tk;
        bus.bird_row  = br;
        bus.pipe_col  = pc;
        bus.pipe_pass = pp;
        bus.press     = pr;
        @(posedge clk);
        m_update();
        #1;
        check_model();
    endtask

    task automatic async_reset_check();
        #3;
        reset = 1'b1;
        #1;
        chk("rst_playing", bus.playing,   0);
        chk("rst_freeze",  bus.freeze,    0);
        chk("rst_flash",   bus.flash,     0);
        chk("rst_over",    bus.over,      0);
        chk("rst_clear",   bus.clear_req, 0);
        chk("rst_tens",    bus.score_tens, 0);
        chk("rst_ones",    bus.score_ones, 0);
        m_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_model();
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.tick      = 1'b0;
        bus.bird_row  = '0;
        bus.pipe_col  = '0;
        bus.pipe_pass = 1'b0;
        bus.press     = 1'b0;
        m_reset();
        #12;
        reset = 1'b0;
        #1;
        check_model();

        // Start and three clean passes.
        step(1, 0, 5, 16'h0000, 0, 0);
        chk("play_entry", bus.playing, 1);
        repeat (3) step(1, 1, 5, 16'h0000, 1, 0);
        chk("score3_tens", bus.score_tens, 0);
        chk("score3_ones", bus.score_ones, 3);

        // Pipe hit at row 5, then blink through FLASH.
        step(1, 1, 5, 16'h0020, 0, 0);
        chk("hit_freeze",  bus.freeze,  1);
        chk("hit_flash",   bus.flash,   1);
        chk("hit_playing", bus.playing, 0);
        for (int k = 1; k <= FLASH_TICKS; k++) begin
            step(1, 0, 5, 16'h0000, 0, 0);
            step(1, 1, 5, 16'h0000, 0, 0);
            if (k < FLASH_TICKS) chk("flash_toggle", bus.flash, 8'((k % 2) == 0));
        end
        chk("over_after_flash", bus.over, 1);

        // Holdoff: early press ignored, press after the 4th tick accepted.
        repeat (2) step(1, 1, 5, 16'h0000, 0, 0);
        step(1, 0, 5, 16'h0000, 0, 1);
        chk("early_press_over",  bus.over,      1);
        chk("early_press_clear", bus.clear_req, 0);
        repeat (2) step(1, 1, 5, 16'h0000, 0, 0);
        step(0, 0, 5, 16'h0000, 0, 1);
        chk("accept_clear", bus.clear_req, 1);
        chk("accept_over",  bus.over,      0);
        step(0, 0, 5, 16'h0000, 0, 0);
        chk("clear_pulse_end", bus.clear_req, 0);

        // Hit and pass on the same tick with score 07.
        step(1, 0, 5, 16'h0000, 0, 0);
        repeat (7) step(1, 1, 5, 16'h0000, 1, 0);
        step(1, 1, 5, 16'h0020, 1, 0);
        chk("tie_freeze", bus.freeze,     1);
        chk("tie_ones",   bus.score_ones, 7);
        repeat (FLASH_TICKS + HOLDOFF_TICKS) step(1, 1, 5, 16'h0000, 0, 0);
        step(0, 0, 5, 16'h0000, 0, 1);
        chk("tie_round_clear", bus.clear_req, 1);

        // Digit carry 09 -> 10, saturation at 99, ground collision.
        step(1, 0, 5, 16'h0000, 0, 0);
        repeat (9) step(1, 1, 5, 16'h0000, 1, 0);
        chk("s09_ones", bus.score_ones, 9);
        step(1, 1, 5, 16'h0000, 1, 0);
        chk("s10_tens", bus.score_tens, 1);
        chk("s10_ones", bus.score_ones, 0);
        repeat (89) step(1, 1, 5, 16'h0000, 1, 0);
        step(1, 1, 5, 16'h0000, 1, 0);
        chk("s99_tens", bus.score_tens, 9);
        chk("s99_ones", bus.score_ones, 9);
        step(1, 1, 0, 16'h0000, 0, 0);
        chk("ground_hit", bus.freeze, 1);

        // Asynchronous reset in FLASH, then restart.
        step(1, 1, 5, 16'h0000, 0, 0);
        async_reset_check();
        step(1, 0, 5, 16'h0000, 0, 0);
        chk("restart_play", bus.playing, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] pc;
            pc = 16'($urandom & $urandom & $urandom);
            step(($urandom_range(0, 19) != 0), $urandom_range(0, 1),
                 4'($urandom_range(0, ROWS - 1)), pc,
                 $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 499) == 0) async_reset_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
